dist_top: RTL and testbench
===========================

DIST_TOP -- requirements
Module: dist_top

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning per-channel FIFO depth; it is a power of two and at least 2.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 SynReset  input  1  synchronous, active-high reset.
REQ-005 i_DataValid_D  input  1  upstream beat present.
REQ-006 i_DataIn_D  input  WIDTH  upstream data.
REQ-007 i_Dest_D  input  2  destination: 0=A, 1=B, 2=C, 3=broadcast to A, B and C.
REQ-008 o_DataGrant_D  output  1  beat accepted this cycle (combinational).
REQ-009 o_DataValid_A/B/C  output  1 each  channel FIFO non-empty.
REQ-010 o_DataOut_A/B/C  output  WIDTH each  head-of-FIFO data (show-ahead).
REQ-011 i_DataGrant_A/B/C  input  1 each  downstream ready for that channel.

Function
REQ-012 Each channel SHALL own an independent FIFO of FIFO_DEPTH entries, with occupancy count 0..FIFO_DEPTH.
REQ-013 o_DataGrant_D SHALL be 1 when i_DataValid_D=1 and the addressed FIFO is not full; for Dest=3, all three FIFOs must be not full.
REQ-014 On an accepted beat, the data SHALL be written at the next CLK edge into the addressed FIFO, or into all three FIFOs for broadcast.
REQ-015 A beat with i_DataValid_D=1 and o_DataGrant_D=0 SHALL be dropped; no FIFO state changes and no partial broadcast write occurs.
REQ-016 o_DataValid_X SHALL equal (count_X != 0), and o_DataOut_X SHALL present the oldest entry with no extra cycle of latency.
REQ-017 A pop of channel X SHALL occur when o_DataValid_X=1 and i_DataGrant_X=1; the next entry, if any, is presented in the following cycle.
REQ-018 Write-to-o_DataValid latency SHALL be 1 cycle: a beat accepted at edge N is visible after edge N.
REQ-019 Simultaneous push and pop on a non-empty channel SHALL leave the count unchanged.
REQ-020 A channel that is full and popped in the same cycle SHALL NOT accept a push in that cycle, because the full check uses the pre-edge count.
REQ-021 Pop on an empty channel SHALL be ignored.
REQ-022 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-023 The three output channels SHALL be mutually independent; a stall on one SHALL NOT block pushes to another except via the broadcast rule in REQ-013.
REQ-024 Per-channel ordering SHALL be preserved: FIFO order equals acceptance order.

Reset
REQ-025 While SynReset=1 at a CLK edge, all counts and pointers SHALL clear to 0, so that o_DataValid_A/B/C=0 after that edge.
REQ-026 While SynReset=1, o_DataGrant_D SHALL be 0, and input and pop activity in that cycle SHALL be ignored.
REQ-027 o_DataOut_X SHALL be 0 after reset until the first write to channel X; FIFO storage contents need not be cleared.
REQ-028 A reset asserted mid-stream SHALL discard all buffered data without any partial pop.

Configuration
REQ-029 When macro DIST_TOP_DROP_CNT_EN is defined, the block SHALL add output port o_DropCnt, 8 bits wide, as a saturating count of dropped beats per REQ-015.
REQ-030 o_DropCnt SHALL increment by 1 per dropped beat, hold at 255, and clear on SynReset.
REQ-031 When DIST_TOP_DROP_CNT_EN is undefined, the o_DropCnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Routing: with downstream grants=1, send 0x10/Dest0, 0x11/Dest1, 0x12/Dest2 on consecutive cycles -> each appears once, 1 cycle after its push, on A, B and C respectively.
REQ-033 Fill/drop: with i_DataGrant_A=0, send 10 beats 0..9 to Dest0 (FIFO_DEPTH=8) -> o_DataGrant_D=1 for beats 0..7 and 0 for 8..9; after raising the grant, A outputs exactly 0..7 in order; o_DropCnt=2 if enabled.
REQ-034 Broadcast blocking: fill B with 8 beats (i_DataGrant_B=0), then send 0xAA/Dest3 -> dropped, A and C stay empty; pop one entry from B, resend -> accepted, and 0xAA appears on A, B and C.
REQ-035 Concurrent push/pop: with A holding 4 entries and i_DataGrant_A=1, push 1 beat/cycle for 6 cycles -> occupancy stays 4 and order is preserved.
REQ-036 Reset mid-operation: with A=3, B=8, C=1 entries, pulse SynReset for 1 cycle -> all o_DataValid=0 next cycle, and a subsequent push of 0x55/Dest2 appears on C alone.
REQ-037 Saturation (macro on): drop 300 beats to a full channel -> o_DropCnt=255.

Source files
------------

// File: rtl/dist_top.sv
`default_nettype none
// ============================================================================
// Module   : dist_top
// Brief    : One-to-three beat distributor with per-channel show-ahead FIFOs
//            and all-or-nothing broadcast. Define DIST_TOP_DROP_CNT_EN to add
//            the saturating o_DropCnt output.
// Revision : 1.0 - initial release
// ============================================================================
module dist_top #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             CLK,
    input  logic             SynReset,
    input  logic             i_DataValid_D,
    input  logic [WIDTH-1:0] i_DataIn_D,
    input  logic [1:0]       i_Dest_D,
    output logic             o_DataGrant_D,
    output logic             o_DataValid_A,
    output logic             o_DataValid_B,
    output logic             o_DataValid_C,
    output logic [WIDTH-1:0] o_DataOut_A,
    output logic [WIDTH-1:0] o_DataOut_B,
    output logic [WIDTH-1:0] o_DataOut_C,
`ifdef DIST_TOP_DROP_CNT_EN
    output logic [7:0]       o_DropCnt,
`endif
    input  logic             i_DataGrant_A,
    input  logic             i_DataGrant_B,
    input  logic             i_DataGrant_C
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [2:0]       w_full;
    logic [2:0]       w_valid;
    logic [2:0]       w_push;
    logic [2:0]       w_pop;
    logic [2:0]       w_popReq;
    logic             w_grant;
    logic [WIDTH-1:0] w_head [3];

    assign w_popReq = {i_DataGrant_C, i_DataGrant_B, i_DataGrant_A};

    // Broadcast needs room in every channel so it is never partially written.
    always_comb begin
        w_grant = 1'b0;
        if (!SynReset && i_DataValid_D) begin
            if (i_Dest_D == 2'd3) begin
                w_grant = (w_full == 3'b000);
            end else begin
                w_grant = !w_full[i_Dest_D];
            end
        end
    end

    assign o_DataGrant_D = w_grant;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_chan
            logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
            logic [c_PTR_W-1:0] r_rdPtr;
            logic [c_PTR_W-1:0] r_wrPtr;
            logic [c_CNT_W-1:0] r_cnt;

            assign w_full[i]  = (r_cnt == c_CNT_W'(FIFO_DEPTH));
            assign w_valid[i] = (r_cnt != '0);
            assign w_push[i]  = w_grant && ((i_Dest_D == 2'(i)) || (i_Dest_D == 2'd3));
            assign w_pop[i]   = w_valid[i] && w_popReq[i] && !SynReset;
            // Gating keeps the output at zero whenever nothing valid is held.
            assign w_head[i]  = w_valid[i] ? r_mem[r_rdPtr] : '0;

            always_ff @(posedge CLK) begin
                if (w_push[i]) begin
                    r_mem[r_wrPtr] <= i_DataIn_D;
                end
            end

            always_ff @(posedge CLK) begin
                if (SynReset) begin
                    r_rdPtr <= '0;
                    r_wrPtr <= '0;
                    r_cnt   <= '0;
                end else begin
                    if (w_push[i]) begin
                        r_wrPtr <= r_wrPtr + 1'b1;
                    end
                    if (w_pop[i]) begin
                        r_rdPtr <= r_rdPtr + 1'b1;
                    end
                    case ({w_push[i], w_pop[i]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    assign o_DataValid_A = w_valid[0];
    assign o_DataValid_B = w_valid[1];
    assign o_DataValid_C = w_valid[2];
    assign o_DataOut_A   = w_head[0];
    assign o_DataOut_B   = w_head[1];
    assign o_DataOut_C   = w_head[2];

`ifdef DIST_TOP_DROP_CNT_EN
    logic [7:0] r_dropCnt;
    logic       w_drop;

    assign w_drop = i_DataValid_D && !w_grant && !SynReset;

    always_ff @(posedge CLK) begin
        if (SynReset) begin
            r_dropCnt <= '0;
        end else if (w_drop && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 1'b1;
        end
    end

    assign o_DropCnt = r_dropCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dist_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_dist_top
// Brief    : Directed bench for dist_top with a queue-based reference model
//            checked every cycle. Honours DIST_TOP_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dist_top;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             SynReset;
    logic             dvIn;
    logic [WIDTH-1:0] dIn;
    logic [1:0]       dest;
    logic             grant;
    logic             vA, vB, vC;
    logic [WIDTH-1:0] dA, dB, dC;
    logic             gA, gB, gC;
`ifdef DIST_TOP_DROP_CNT_EN
    logic [7:0]       dropCnt;
`endif

    always #5 clk = ~clk;

    dist_top #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) u_dut (
        .CLK           (clk),
        .SynReset      (SynReset),
        .i_DataValid_D (dvIn),
        .i_DataIn_D    (dIn),
        .i_Dest_D      (dest),
        .o_DataGrant_D (grant),
        .o_DataValid_A (vA),
        .o_DataValid_B (vB),
        .o_DataValid_C (vC),
        .o_DataOut_A   (dA),
        .o_DataOut_B   (dB),
        .o_DataOut_C   (dC),
`ifdef DIST_TOP_DROP_CNT_EN
        .o_DropCnt     (dropCnt),
`endif
        .i_DataGrant_A (gA),
        .i_DataGrant_B (gB),
        .i_DataGrant_C (gC)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus a saturating drop tally.
    logic [WIDTH-1:0] q [3][$];
    int               dropExp;
    bit               modelOn = 1'b0;
    logic [2:0]       mFull;
    logic             mGrant;
    logic [2:0]       mGin;
    logic [2:0]       mValid;
    logic [WIDTH-1:0] mData [3];

    always @(negedge clk) begin
        if (modelOn) begin
            mValid = {vC, vB, vA};
            mData[0] = dA; mData[1] = dB; mData[2] = dC;
            mGin = {gC, gB, gA};
            for (int i = 0; i < 3; i++) mFull[i] = (q[i].size() == DEPTH);
            if (dest == 2'd3) mGrant = !SynReset && dvIn && (mFull == 3'b000);
            else              mGrant = !SynReset && dvIn && !mFull[dest];
            chk("model_grant", {31'd0, grant}, {31'd0, mGrant});
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_valid%0d", i), {31'd0, mValid[i]}, {31'd0, q[i].size() != 0});
                if (q[i].size() != 0)
                    chk($sformatf("model_data%0d", i), {24'd0, mData[i]}, {24'd0, q[i][0]});
            end
`ifdef DIST_TOP_DROP_CNT_EN
            chk("model_dropcnt", {24'd0, dropCnt}, dropExp);
`endif
            if (SynReset) begin
                for (int i = 0; i < 3; i++) q[i].delete();
                dropExp = 0;
            end else begin
                for (int i = 0; i < 3; i++)
                    if (q[i].size() != 0 && mGin[i]) void'(q[i].pop_front());
                if (mGrant) begin
                    for (int i = 0; i < 3; i++)
                        if (dest == 2'(i) || dest == 2'd3) q[i].push_back(dIn);
                end else if (dvIn && dropExp < 255) begin
                    dropExp++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] ds);
        dvIn = 1'b1; dIn = d; dest = ds;
        step();
    endtask

    initial begin
        SynReset = 1'b1; dvIn = 1'b0; dIn = '0; dest = '0;
        gA = 1'b0; gB = 1'b0; gC = 1'b0;
        dropExp = 0;
        step(); step();
        modelOn = 1'b1;
        SynReset = 1'b0;
        #1;
        chk("reset_vA", {31'd0, vA}, 0);
        chk("reset_vB", {31'd0, vB}, 0);
        chk("reset_vC", {31'd0, vC}, 0);
        chk("reset_dA", {24'd0, dA}, 0);
        chk("reset_dB", {24'd0, dB}, 0);
        chk("reset_dC", {24'd0, dC}, 0);
        step();

        // Routing
        gA = 1'b1; gB = 1'b1; gC = 1'b1;
        send(8'h10, 2'd0);
        chk("route_vA", {31'd0, vA}, 1);
        chk("route_dA", {24'd0, dA}, 32'h10);
        send(8'h11, 2'd1);
        chk("route_dB", {24'd0, dB}, 32'h11);
        chk("route_A_gone", {31'd0, vA}, 0);
        send(8'h12, 2'd2);
        chk("route_dC", {24'd0, dC}, 32'h12);
        chk("route_B_gone", {31'd0, vB}, 0);
        dvIn = 1'b0;
        step();

        // Fill and drop on A
        gA = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dvIn = 1'b1; dIn = 8'(i); dest = 2'd0;
            #1;
            chk($sformatf("fill_grant%0d", i), {31'd0, grant}, (i < 8) ? 1 : 0);
            step();
        end
        dvIn = 1'b0;
        gA = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_dA%0d", i), {24'd0, dA}, i);
            step();
        end
        chk("drain_empty", {31'd0, vA}, 0);
`ifdef DIST_TOP_DROP_CNT_EN
        chk("drop_cnt2", {24'd0, dropCnt}, 2);
`endif

        // Broadcast blocked by a full B
        gB = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 2'd1);
        dvIn = 1'b1; dIn = 8'hAA; dest = 2'd3;
        #1;
        chk("bcast_blocked", {31'd0, grant}, 0);
        step();
        dvIn = 1'b0;
        chk("bcast_A_empty", {31'd0, vA}, 0);
        chk("bcast_C_empty", {31'd0, vC}, 0);
        gB = 1'b1;
        step();
        gB = 1'b0;
        dvIn = 1'b1; dIn = 8'hAA; dest = 2'd3;
        #1;
        chk("bcast_accept", {31'd0, grant}, 1);
        step();
        dvIn = 1'b0;
        chk("bcast_dA", {24'd0, dA}, 32'hAA);
        chk("bcast_dC", {24'd0, dC}, 32'hAA);
        gB = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("bcast_dB", {24'd0, dB}, 32'hAA);
        step();
        chk("bcast_B_empty", {31'd0, vB}, 0);

        // Concurrent push/pop on A
        gA = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 2'd0);
        gA = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dvIn = 1'b1; dIn = 8'(8'h24 + k); dest = 2'd0;
            chk($sformatf("pp_head%0d", k), {24'd0, dA}, 32'h20 + k);
            step();
        end
        dvIn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pp_tail%0d", k), {24'd0, dA}, 32'h26 + k);
            step();
        end
        chk("pp_empty", {31'd0, vA}, 0);

        // Reset mid-stream, with traffic presented during the reset cycle
        gA = 1'b0; gB = 1'b0; gC = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'h40 + i), 2'd0);
        for (int i = 0; i < 8; i++) send(8'(8'h50 + i), 2'd1);
        send(8'h60, 2'd2);
        SynReset = 1'b1; dvIn = 1'b1; dIn = 8'h77; dest = 2'd0; gA = 1'b1;
        #1;
        chk("rst_grant", {31'd0, grant}, 0);
        step();
        SynReset = 1'b0; dvIn = 1'b0; gA = 1'b0;
        chk("rst_vA", {31'd0, vA}, 0);
        chk("rst_vB", {31'd0, vB}, 0);
        chk("rst_vC", {31'd0, vC}, 0);
        send(8'h55, 2'd2);
        dvIn = 1'b0;
        chk("post_rst_vC", {31'd0, vC}, 1);
        chk("post_rst_dC", {24'd0, dC}, 32'h55);
        chk("post_rst_vA", {31'd0, vA}, 0);
        chk("post_rst_vB", {31'd0, vB}, 0);

`ifdef DIST_TOP_DROP_CNT_EN
        // Saturation of the drop counter
        chk("sat_start", {24'd0, dropCnt}, 0);
        for (int i = 0; i < 8; i++) send(8'(i), 2'd0);
        for (int i = 0; i < 300; i++) send(8'hEE, 2'd0);
        dvIn = 1'b0;
        chk("sat_255", {24'd0, dropCnt}, 255);
`endif

        dvIn = 1'b0;
        gA = 1'b1; gB = 1'b1; gC = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("final_vA", {31'd0, vA}, 0);
        chk("final_vC", {31'd0, vC}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
